// File: rtl/div_pkg.sv
// Shared definitions for the divider sequencer: state encoding, default width
// and the positions of quotient/remainder inside the IP dout word.
package div_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    // dout = {quotient, remainder}; slot index selects a DATA_W-wide field
    localparam int unsigned QUOT_SLOT = 1;
    localparam int unsigned REM_SLOT  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/div_ctrl_axis_send_ch.sv
// One AXI-stream style send channel: raises valid while active until its
// handshake completes, then stays quiet until the next request starts.
module axis_send_ch (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic active,
    input  logic ready,
    output logic valid,
    output logic done
);

    logic sent_q, sent_d;

    assign valid = active && !sent_q;
    // done includes the handshake happening this cycle so both channels can finish together
    assign done  = sent_q || (valid && ready);

    always_comb begin
        sent_d = sent_q;
        if (start) begin
            sent_d = 1'b0;
        end else if (done) begin
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and the signed/unsigned divider IPs: steers one
// request at a time, runs both operand handshakes and returns quotient or remainder.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned WATCHDOG = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    input  logic                req_signed,
    input  logic                req_rem,
    input  logic [DATA_W-1:0]   req_src1,
    input  logic [DATA_W-1:0]   req_src2,
    input  logic                flush,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                stall,
    output logic                err,
    output logic [DATA_W-1:0]   div_divisor_data,
    output logic                div_divisor_valid,
    input  logic                div_divisor_ready,
    output logic [DATA_W-1:0]   div_dividend_data,
    output logic                div_dividend_valid,
    input  logic                div_dividend_ready,
    input  logic                div_dout_valid,
    input  logic [2*DATA_W-1:0] div_dout_data,
    output logic [DATA_W-1:0]   divu_divisor_data,
    output logic                divu_divisor_valid,
    input  logic                divu_divisor_ready,
    output logic [DATA_W-1:0]   divu_dividend_data,
    output logic                divu_dividend_valid,
    input  logic                divu_dividend_ready,
    input  logic                divu_dout_valid,
    input  logic [2*DATA_W-1:0] divu_dout_data
);

    localparam int unsigned WD_W = $clog2(WATCHDOG + 2);

    state_t              state_q, state_d;
    logic                sgn_q, sgn_d, rem_q, rem_d;
    logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                err_q, err_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

    logic                accept, ch_active;
    logic                dvs_valid, dvs_done, dvd_valid, dvd_done;
    logic                sel_dvs_ready, sel_dvd_ready, sel_dout_valid;
    logic [2*DATA_W-1:0] sel_dout;

    // Channels stay live in DRAIN: a flushed request must still finish its handshakes
    assign ch_active = (state_q == S_SEND) || (state_q == S_DRAIN);

    axis_send_ch u_divisor_ch (
        .clk    (clk),
        .resetn (resetn),
        .start  (accept),
        .active (ch_active),
        .ready  (sel_dvs_ready),
        .valid  (dvs_valid),
        .done   (dvs_done)
    );

    axis_send_ch u_dividend_ch (
        .clk    (clk),
        .resetn (resetn),
        .start  (accept),
        .active (ch_active),
        .ready  (sel_dvd_ready),
        .valid  (dvd_valid),
        .done   (dvd_done)
    );

    assign sel_dvs_ready  = sgn_q ? div_divisor_ready  : divu_divisor_ready;
    assign sel_dvd_ready  = sgn_q ? div_dividend_ready : divu_dividend_ready;
    assign sel_dout_valid = sgn_q ? div_dout_valid     : divu_dout_valid;
    assign sel_dout       = sgn_q ? div_dout_data      : divu_dout_data;

    assign div_divisor_valid   = sgn_q && dvs_valid;
    assign div_dividend_valid  = sgn_q && dvd_valid;
    assign divu_divisor_valid  = !sgn_q && dvs_valid;
    assign divu_dividend_valid = !sgn_q && dvd_valid;
    assign div_divisor_data    = sgn_q ? src2_q : '0;
    assign div_dividend_data   = sgn_q ? src1_q : '0;
    assign divu_divisor_data   = sgn_q ? '0 : src2_q;
    assign divu_dividend_data  = sgn_q ? '0 : src1_q;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE) && !flush;
    assign resp_data  = resp_data_q;
    assign err        = err_q;
    assign stall      = (state_q == S_SEND) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && req_valid && (req_src2 != '0) && !flush);

    always_comb begin
        state_d     = state_q;
        sgn_d       = sgn_q;
        rem_d       = rem_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        wd_cnt_d    = wd_cnt_q;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    if (req_src2 != '0) begin
                        accept  = 1'b1;
                        sgn_d   = req_signed;
                        rem_d   = req_rem;
                        src1_d  = req_src1;
                        src2_d  = req_src2;
                        state_d = S_SEND;
                    end else begin
                        resp_data_d = '0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (dvs_done && dvd_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving alongside a flush is simply dropped; DRAIN would never see another
                if (sel_dout_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_data_d = rem_q ? sel_dout[REM_SLOT*DATA_W +: DATA_W]
                                            : sel_dout[QUOT_SLOT*DATA_W +: DATA_W];
                        state_d     = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (sel_dout_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            wd_cnt_d = '0;
        end else if (ch_active || (state_q == S_WAIT)) begin
            if (wd_cnt_q != WD_W'(WATCHDOG)) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (wd_cnt_d == WD_W'(WATCHDOG)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sgn_q       <= 1'b0;
            rem_q       <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            sgn_q       <= sgn_d;
            rem_q       <= rem_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider IPs with configurable ready delay and
// latency, a table of directed requests, and hand-written flush/watchdog sequences.
module tb_div_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned WD = 8;

    logic            clk;
    logic            resetn;
    logic            req_valid, req_signed, req_rem, flush;
    logic [DW-1:0]   req_src1, req_src2;
    logic            req_ready, resp_valid, stall, err;
    logic [DW-1:0]   resp_data;
    logic [DW-1:0]   div_divisor_data, div_dividend_data, divu_divisor_data, divu_dividend_data;
    logic            div_divisor_valid, div_dividend_valid, divu_divisor_valid, divu_dividend_valid;
    logic            div_divisor_ready, div_dividend_ready, divu_divisor_ready, divu_dividend_ready;
    logic            div_dout_valid, divu_dout_valid;
    logic [2*DW-1:0] div_dout_data, divu_dout_data;

    div_ctrl #(.DATA_W(DW), .WATCHDOG(WD)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .req_valid           (req_valid),
        .req_signed          (req_signed),
        .req_rem             (req_rem),
        .req_src1            (req_src1),
        .req_src2            (req_src2),
        .flush               (flush),
        .req_ready           (req_ready),
        .resp_valid          (resp_valid),
        .resp_data           (resp_data),
        .stall               (stall),
        .err                 (err),
        .div_divisor_data    (div_divisor_data),
        .div_divisor_valid   (div_divisor_valid),
        .div_divisor_ready   (div_divisor_ready),
        .div_dividend_data   (div_dividend_data),
        .div_dividend_valid  (div_dividend_valid),
        .div_dividend_ready  (div_dividend_ready),
        .div_dout_valid      (div_dout_valid),
        .div_dout_data       (div_dout_data),
        .divu_divisor_data   (divu_divisor_data),
        .divu_divisor_valid  (divu_divisor_valid),
        .divu_divisor_ready  (divu_divisor_ready),
        .divu_dividend_data  (divu_dividend_data),
        .divu_dividend_valid (divu_dividend_valid),
        .divu_dividend_ready (divu_dividend_ready),
        .divu_dout_valid     (divu_dout_valid),
        .divu_dout_data      (divu_dout_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // IP model state; index 0 = signed div, 1 = unsigned divu
    logic [1:0]      m_dvs_ready, m_dvd_ready, m_dout_valid;
    logic [2*DW-1:0] m_dout [2];
    logic [1:0]      o_dvs_valid, o_dvd_valid;
    logic [DW-1:0]   o_dvs_data [2];
    logic [DW-1:0]   o_dvd_data [2];

    assign div_divisor_ready   = m_dvs_ready[0];
    assign div_dividend_ready  = m_dvd_ready[0];
    assign divu_divisor_ready  = m_dvs_ready[1];
    assign divu_dividend_ready = m_dvd_ready[1];
    assign div_dout_valid      = m_dout_valid[0];
    assign divu_dout_valid     = m_dout_valid[1];
    assign div_dout_data       = m_dout[0];
    assign divu_dout_data      = m_dout[1];
    assign o_dvs_valid         = {divu_divisor_valid, div_divisor_valid};
    assign o_dvd_valid         = {divu_dividend_valid, div_dividend_valid};
    assign o_dvs_data[0]       = div_divisor_data;
    assign o_dvs_data[1]       = divu_divisor_data;
    assign o_dvd_data[0]       = div_dividend_data;
    assign o_dvd_data[1]       = divu_dividend_data;

    int            dvs_dly, dvd_dly, lat;
    bit            no_dout;
    int            wait_dvs [2], wait_dvd [2], lat_cnt [2], vc_dvs [2], vc_dvd [2];
    bit            got_dvs [2], got_dvd [2], busy [2];
    logic [DW-1:0] op_a [2], op_b [2], prev_dvs [2], q_t, r_t;
    int            dout_cnt, dout_cyc;
    bit            dvs_chg;

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            vc_dvs[i] = 0;
            vc_dvd[i] = 0;
        end
        dout_cnt = 0;
        dout_cyc = -100;
        dvs_chg  = 1'b0;
    endtask

    // Ready/result decisions are made on the falling edge and take effect at the next rising edge
    initial begin
        m_dvs_ready = '0; m_dvd_ready = '0; m_dout_valid = '0;
        m_dout[0] = '0; m_dout[1] = '0;
        dvs_dly = 0; dvd_dly = 0; lat = 1; no_dout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_dvs[i] = 0; wait_dvd[i] = 0; lat_cnt[i] = 0;
            got_dvs[i] = 0; got_dvd[i] = 0; busy[i] = 0;
        end
        clear_stats();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m_dout_valid[i] = 1'b0;
                if (!resetn) begin
                    m_dvs_ready[i] = 1'b0; m_dvd_ready[i] = 1'b0;
                    wait_dvs[i] = 0; wait_dvd[i] = 0;
                    got_dvs[i] = 0; got_dvd[i] = 0; busy[i] = 0;
                    continue;
                end
                if (o_dvs_valid[i]) begin
                    vc_dvs[i]++;
                    if (vc_dvs[i] > 1 && o_dvs_data[i] !== prev_dvs[i]) dvs_chg = 1'b1;
                    prev_dvs[i] = o_dvs_data[i];
                end
                if (o_dvd_valid[i]) vc_dvd[i]++;
                m_dvs_ready[i] = o_dvs_valid[i] && !got_dvs[i] && (wait_dvs[i] >= dvs_dly);
                if (m_dvs_ready[i]) begin
                    got_dvs[i] = 1'b1; op_b[i] = o_dvs_data[i];
                end else if (o_dvs_valid[i]) begin
                    wait_dvs[i]++;
                end
                m_dvd_ready[i] = o_dvd_valid[i] && !got_dvd[i] && (wait_dvd[i] >= dvd_dly);
                if (m_dvd_ready[i]) begin
                    got_dvd[i] = 1'b1; op_a[i] = o_dvd_data[i];
                end else if (o_dvd_valid[i]) begin
                    wait_dvd[i]++;
                end
                if (busy[i]) begin
                    lat_cnt[i]--;
                    if (lat_cnt[i] <= 0) begin
                        busy[i] = 1'b0;
                        if (!no_dout) begin
                            if (i == 0) begin
                                q_t = $signed(op_a[i]) / $signed(op_b[i]);
                                r_t = $signed(op_a[i]) % $signed(op_b[i]);
                            end else begin
                                q_t = op_a[i] / op_b[i];
                                r_t = op_a[i] % op_b[i];
                            end
                            m_dout[i]       = {q_t, r_t};
                            m_dout_valid[i] = 1'b1;
                            dout_cnt++;
                            dout_cyc = cyc;
                        end
                    end
                end else if (got_dvs[i] && got_dvd[i]) begin
                    busy[i] = 1'b1; lat_cnt[i] = lat;
                    got_dvs[i] = 1'b0; got_dvd[i] = 1'b0;
                    wait_dvs[i] = 0; wait_dvd[i] = 0;
                end
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit        sgn;
        bit        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int        dvs_dly;
        int        dvd_dly;
        int        lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int id, input vec_t v);
        int  acc_cyc, resp_cyc, stall_bad, sel, unsel;
        bit  got_resp;
        logic stall_at_resp;
        string p;
        p = $sformatf("v%0d", id);
        drive_edge();
        dvs_dly = v.dvs_dly; dvd_dly = v.dvd_dly; lat = v.lat; no_dout = 1'b0;
        clear_stats();
        req_signed = v.sgn; req_rem = v.rem; req_src1 = v.a; req_src2 = v.b;
        req_valid = 1'b1;
        sample();
        acc_cyc = cyc;
        check({p, "_accept_stall"}, 64'(stall), 64'(v.b != 0));
        check({p, "_accept_ready"}, 64'(req_ready), 64'd1);
        drive_edge();
        req_valid = 1'b0;
        got_resp = 1'b0; stall_bad = 0; resp_cyc = 0; stall_at_resp = 1'bx;
        for (int k = 0; k < 100; k++) begin
            sample();
            if (resp_valid) begin
                got_resp = 1'b1; resp_cyc = cyc; stall_at_resp = stall;
                break;
            end
            if (!stall) stall_bad++;
        end
        check({p, "_resp_seen"}, 64'(got_resp), 64'd1);
        check({p, "_resp_data"}, 64'(resp_data), 64'(v.exp));
        check({p, "_stall_done"}, 64'(stall_at_resp), 64'd0);
        check({p, "_stall_busy"}, 64'(stall_bad), 64'd0);
        sel = v.sgn ? 0 : 1;
        unsel = 1 - sel;
        if (v.b == 0) begin
            check({p, "_dz_ip_valids"}, 64'(vc_dvs[0] + vc_dvd[0] + vc_dvs[1] + vc_dvd[1]), 64'd0);
            check({p, "_dz_latency"}, 64'(resp_cyc - acc_cyc), 64'd1);
        end else begin
            check({p, "_divisor_valid_cycles"}, 64'(vc_dvs[sel]), 64'(v.dvs_dly + 1));
            check({p, "_dividend_valid_cycles"}, 64'(vc_dvd[sel]), 64'(v.dvd_dly + 1));
            check({p, "_unsel_valids"}, 64'(vc_dvs[unsel] + vc_dvd[unsel]), 64'd0);
            check({p, "_divisor_data_stable"}, 64'(dvs_chg), 64'd0);
            check({p, "_resp_after_dout"}, 64'(resp_cyc - dout_cyc), 64'd1);
        end
        sample();
        check({p, "_resp_one_cycle"}, 64'(resp_valid), 64'd0);
        check({p, "_back_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  start_cnt, ready_bad, entry_cyc;
        bit  resp_seen, dout_seen;

        vecs[0] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 0, 0, 20};
        vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'd10,         32'd5,         2, 0, 4};
        vecs[2] = '{1'b1, 1'b0, 32'd1234,      32'd0,          32'd0,         0, 0, 1};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 0, 0, 2};
        vecs[4] = '{1'b0, 1'b0, 32'd100,       32'd7,          32'd14,        0, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'd20,        32'hFFFF_FFFD,  32'hFFFF_FFFA, 0, 0, 3};
        vecs[6] = '{1'b1, 1'b1, 32'd20,        32'hFFFF_FFFD,  32'd2,         1, 1, 5};
        vecs[7] = '{1'b0, 1'b1, 32'd55,        32'd0,          32'd0,         0, 0, 1};
        vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 0, 0, 1};

        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_rem = 1'b0;
        req_src1 = '0; req_src2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_ip_valids", 64'({o_dvs_valid, o_dvd_valid}), 64'd0);
        check("rst_ip_data", 64'(div_divisor_data | div_dividend_data | divu_divisor_data | divu_dividend_data), 64'd0);
        drive_edge();
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Flush while waiting for the result
        drive_edge();
        dvs_dly = 0; dvd_dly = 0; lat = 10; no_dout = 1'b0;
        clear_stats();
        req_signed = 1'b1; req_rem = 1'b0; req_src1 = 32'd50; req_src2 = 32'd5; req_valid = 1'b1;
        drive_edge();
        req_valid = 1'b0;
        drive_edge();
        flush = 1'b1;
        drive_edge();
        flush = 1'b0;
        sample();
        check("fw_stall_drain", 64'(stall), 64'd0);
        check("fw_ready_drain", 64'(req_ready), 64'd0);
        resp_seen = 1'b0; ready_bad = 0; dout_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (dout_cnt > 0) begin
                dout_seen = 1'b1;
                break;
            end
            if (req_ready) ready_bad++;
            if (resp_valid) resp_seen = 1'b1;
            sample();
        end
        check("fw_dout_seen", 64'(dout_seen), 64'd1);
        check("fw_ready_held_low", 64'(ready_bad), 64'd0);
        sample();
        if (resp_valid) resp_seen = 1'b1;
        check("fw_ready_after", 64'(req_ready), 64'd1);
        check("fw_no_resp", 64'(resp_seen), 64'd0);

        // Flush while the divisor is still waiting for ready
        drive_edge();
        dvs_dly = 4; dvd_dly = 0; lat = 3; no_dout = 1'b0;
        clear_stats();
        req_signed = 1'b1; req_rem = 1'b0; req_src1 = 32'd9; req_src2 = 32'd4; req_valid = 1'b1;
        drive_edge();
        req_valid = 1'b0;
        drive_edge();
        flush = 1'b1;
        sample();
        check("fs_divisor_valid_send", 64'(div_divisor_valid), 64'd1);
        check("fs_dividend_done", 64'(vc_dvd[0]), 64'd1);
        drive_edge();
        flush = 1'b0;
        sample();
        check("fs_stall_drain", 64'(stall), 64'd0);
        check("fs_ready_drain", 64'(req_ready), 64'd0);
        check("fs_divisor_valid_drain", 64'(div_divisor_valid), 64'd1);
        resp_seen = 1'b0; dout_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (resp_valid) resp_seen = 1'b1;
            if (dout_cnt > 0) begin
                dout_seen = 1'b1;
                break;
            end
            sample();
        end
        check("fs_dout_seen", 64'(dout_seen), 64'd1);
        check("fs_divisor_valid_cycles", 64'(vc_dvs[0]), 64'd5);
        sample();
        if (resp_valid) resp_seen = 1'b1;
        check("fs_ready_after", 64'(req_ready), 64'd1);
        check("fs_no_resp", 64'(resp_seen), 64'd0);

        // Watchdog: the IP never answers
        drive_edge();
        resetn = 1'b0;
        sample();
        drive_edge();
        resetn = 1'b1;
        check("wd_err_clear_start", 64'(err), 64'd0);
        dvs_dly = 0; dvd_dly = 0; lat = 1; no_dout = 1'b1;
        clear_stats();
        req_signed = 1'b0; req_rem = 1'b0; req_src1 = 32'd30; req_src2 = 32'd3; req_valid = 1'b1;
        drive_edge();
        req_valid = 1'b0;
        sample();
        entry_cyc = cyc;
        for (int k = 0; k < 40; k++) begin
            if (err) break;
            sample();
        end
        check("wd_err_rise", 64'(err), 64'd1);
        check("wd_err_delay", 64'(cyc - entry_cyc), 64'd8);
        repeat (5) sample();
        check("wd_err_sticky", 64'(err), 64'd1);
        check("wd_state_held", 64'(stall), 64'd1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_err", 64'(err), 64'd0);
        check("ar_stall", 64'(stall), 64'd0);
        check("ar_req_ready", 64'(req_ready), 64'd1);
        check("ar_resp", 64'({resp_valid, resp_data}), 64'd0);
        check("ar_ip_valids", 64'({o_dvs_valid, o_dvd_valid}), 64'd0);
        sample();
        drive_edge();
        resetn = 1'b1;
        no_dout = 1'b0;
        sample();
        check("ar_err_after", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
